// File: rtl/uart_pkg.sv
// UART shared definitions: parity encodings and tx state type.
// Shared by the transmitter and the future receiver.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

endpackage

// File: rtl/uart_tx_stream.sv
// Stream-fed UART transmitter: start, LSB-first data, optional parity, stop.
// Accepts the next word in the last stop clk so frames run back to back.
module uart_tx_stream
  import uart_pkg::*;
#(
  parameter int CLKDIV    = 16,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = PARITY_NONE,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 txd,
  output logic                 busy
);

  localparam int CW = $clog2(CLKDIV);
  localparam int IW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] T_LAST = CW'(CLKDIV - 1);
  localparam logic [CW-1:0] T_ONE  = CW'(1);
  localparam logic [IW-1:0] B_LAST = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] S_LAST = IW'(STOP_BITS - 1);
  localparam bit HAS_PAR = (PARITY != PARITY_NONE);
  localparam bit ODD     = (PARITY == PARITY_ODD);

  generate
    if (CLKDIV < 2) begin : g_bad_div
      $error("CLKDIV must be >= 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_bits
      $error("DATA_BITS must be 5..9");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
      $error("STOP_BITS must be 1 or 2");
    end
  endgenerate

  tx_state_t            state;
  logic [CW-1:0]        tmr;
  logic [IW-1:0]        idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par;

  logic take;
  logic tmr_done;
  logic last_stop;

  assign take      = in_valid & in_ready;
  assign tmr_done  = (tmr == '0);
  assign last_stop = (idx == S_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= TX_IDLE;
      txd      <= 1'b1;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      tmr      <= '0;
      idx      <= '0;
      shreg    <= '0;
      par      <= 1'b0;
    end else if (take) begin
      // in_ready is only high in IDLE or the last stop clk
      state    <= TX_START;
      shreg    <= in_data;
      par      <= (^in_data) ^ ODD;
      txd      <= 1'b0;
      busy     <= 1'b1;
      in_ready <= 1'b0;
      tmr      <= T_LAST;
      idx      <= '0;
    end else begin
      unique case (state)
        TX_IDLE: begin
          txd      <= 1'b1;
          busy     <= 1'b0;
          in_ready <= 1'b1;
        end
        TX_START: begin
          if (tmr_done) begin
            state <= TX_DATA;
            txd   <= shreg[0];
            shreg <= shreg >> 1;
            tmr   <= T_LAST;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        TX_DATA: begin
          if (tmr_done) begin
            tmr <= T_LAST;
            if (idx == B_LAST) begin
              idx <= '0;
              if (HAS_PAR) begin
                state <= TX_PARITY;
                txd   <= par;
              end else begin
                state <= TX_STOP;
                txd   <= 1'b1;
              end
            end else begin
              idx   <= idx + 1'b1;
              txd   <= shreg[0];
              shreg <= shreg >> 1;
            end
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        TX_PARITY: begin
          if (tmr_done) begin
            state <= TX_STOP;
            txd   <= 1'b1;
            tmr   <= T_LAST;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        TX_STOP: begin
          if (tmr_done) begin
            if (last_stop) begin
              state    <= TX_IDLE;
              busy     <= 1'b0;
              in_ready <= 1'b1;
            end else begin
              idx <= idx + 1'b1;
              tmr <= T_LAST;
            end
          end else begin
            tmr <= tmr - 1'b1;
            // open the window one clk early so in_ready is registered
            if (last_stop && tmr == T_ONE)
              in_ready <= 1'b1;
          end
        end
        default: state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_stream.sv
// Self-checking bench: frame-level model of three transmitter configs.
// Per-cycle compare plus hand-computed frame literals.
module tb_uart_tx_stream;
  import uart_pkg::*;

  localparam int N  = 3;
  localparam int CD = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] v;
  logic [N-1:0] rdy;
  logic [N-1:0] txd;
  logic [N-1:0] busy;
  logic [7:0]   d [N];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx_stream #(
    .CLKDIV(CD), .DATA_BITS(8), .PARITY(PARITY_NONE), .STOP_BITS(1)
  ) u0 (
    .clk(clk), .rst(rst), .in_data(d[0]), .in_valid(v[0]),
    .in_ready(rdy[0]), .txd(txd[0]), .busy(busy[0])
  );

  uart_tx_stream #(
    .CLKDIV(CD), .DATA_BITS(8), .PARITY(PARITY_ODD), .STOP_BITS(1)
  ) u1 (
    .clk(clk), .rst(rst), .in_data(d[1]), .in_valid(v[1]),
    .in_ready(rdy[1]), .txd(txd[1]), .busy(busy[1])
  );

  uart_tx_stream #(
    .CLKDIV(CD), .DATA_BITS(8), .PARITY(PARITY_EVEN), .STOP_BITS(2)
  ) u2 (
    .clk(clk), .rst(rst), .in_data(d[2]), .in_valid(v[2]),
    .in_ready(rdy[2]), .txd(txd[2]), .busy(busy[2])
  );

  function automatic int par_of(int k);
    return (k == 1) ? PARITY_ODD : (k == 2) ? PARITY_EVEN : PARITY_NONE;
  endfunction

  function automatic int sb_of(int k);
    return (k == 2) ? 2 : 1;
  endfunction

  function automatic int flen(int k);
    return (1 + 8 + ((par_of(k) != 0) ? 1 : 0) + sb_of(k)) * CD;
  endfunction

  // Bit b of the frame for word wd
  function automatic logic fbit(int k, logic [7:0] wd, int b);
    if (b == 0) return 1'b0;
    if (b <= 8) return wd[b-1];
    if (b == 9 && par_of(k) == PARITY_ODD) return ~(^wd);
    if (b == 9 && par_of(k) == PARITY_EVEN) return ^wd;
    return 1'b1;
  endfunction

  // Model: position within the current frame, or idle
  bit         started = 1'b0;
  bit         act   [N];
  int         pos   [N];
  logic [7:0] w     [N];
  bit         m_rdy [N];
  bit         m_hs  [N];

  always @(posedge clk) begin
    started = 1'b1;
    for (int k = 0; k < N; k++) begin
      m_hs[k] = 1'b0;
      if (rst) begin
        act[k]   = 1'b0;
        pos[k]   = 0;
        m_rdy[k] = 1'b0;
      end else begin
        m_hs[k] = v[k] && m_rdy[k];
        if (act[k] && pos[k] < flen(k) - 1) begin
          pos[k]++;
        end else if (m_hs[k]) begin
          act[k] = 1'b1;
          pos[k] = 0;
          w[k]   = d[k];
        end else begin
          act[k] = 1'b0;
        end
        m_rdy[k] = !act[k] || pos[k] == flen(k) - 1;
      end
    end
  end

  task automatic chk(input string nm, input int k,
                     input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s[%0d] t=%0t got %h expected %h", nm, k, $time, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      for (int k = 0; k < N; k++) begin
        chk("txd", k, 32'(txd[k]),
            32'(act[k] ? fbit(k, w[k], pos[k] / CD) : 1'b1));
        chk("busy", k, 32'(busy[k]), 32'(act[k]));
        chk("in_ready", k, 32'(rdy[k]), 32'(m_rdy[k]));
      end
    end
  end

  task automatic wait_hs(input int k);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!m_hs[k] && n < 200);
    if (!m_hs[k]) begin
      checks++;
      errors++;
      $display("FAIL hs_timeout[%0d] t=%0t got none expected handshake", k, $time);
    end
  endtask

  // Returns at the negedge right after the handshake edge (frame pos 0)
  task automatic send(input int k, input logic [7:0] wd);
    v[k] = 1'b1;
    d[k] = wd;
    wait_hs(k);
    v[k] = 1'b0;
  endtask

  task automatic grab(input int k, input int n, output logic [255:0] c);
    c = '0;
    for (int i = 0; i < n; i++) begin
      c[i] = txd[k];
      @(negedge clk);
    end
  endtask

  function automatic logic [31:0] mid(logic [255:0] c, int nb);
    logic [31:0] m;
    m = '0;
    for (int b = 0; b < nb; b++) m[b] = c[CD * b + 1];
    return m;
  endfunction

  logic [255:0] c;
  int           lows;
  int           hs_cnt;

  initial begin
    v = '0;
    for (int k = 0; k < N; k++) d[k] = 8'h00;
    v[0] = 1'b1;
    d[0] = 8'hAA;

    // reset held with valid asserted
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_txd", 0, 32'(txd[0]), 32'd1);
      chk("rst_ready", 0, 32'(rdy[0]), 32'd0);
      chk("rst_busy", 0, 32'(busy[0]), 32'd0);
    end
    rst  = 1'b0;
    v[0] = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 0, 32'(rdy[0]), 32'd1);
    chk("idle_busy", 0, 32'(busy[0]), 32'd0);

    // single 0xA5, 8N1
    send(0, 8'hA5);
    grab(0, 40, c);
    chk("frame_a5", 0, mid(c, 10), 32'h34A);
    chk("a5_busy_end", 0, 32'(busy[0]), 32'd0);
    chk("a5_ready_end", 0, 32'(rdy[0]), 32'd1);

    // back-to-back with valid held
    repeat (3) @(negedge clk);
    v[0] = 1'b1;
    d[0] = 8'h00;
    wait_hs(0);
    d[0] = 8'hFF;
    fork
      grab(0, 120, c);
      begin
        wait_hs(0);
        d[0] = 8'h55;
        wait_hs(0);
        v[0] = 1'b0;
      end
    join
    chk("b2b_frames", 0, mid(c, 30), {2'b00, 10'h2AA, 10'h3FE, 10'h200});
    chk("b2b_busy_end", 0, 32'(busy[0]), 32'd0);

    // odd parity, 8O1
    send(1, 8'h01);
    grab(1, 44, c);
    chk("odd_par_bit", 1, 32'(c[37]), 32'd0);
    chk("odd_frame", 1, mid(c, 11), 32'({1'b1, 1'b0, 8'h01, 1'b0}));

    // even parity, 8E2
    send(2, 8'h01);
    grab(2, 48, c);
    chk("even_frame", 2, mid(c, 12), 32'({2'b11, 1'b1, 8'h01, 1'b0}));
    chk("stop2_len", 2, 32'(c[47:40]), 32'hFF);
    chk("e2_busy_end", 2, 32'(busy[2]), 32'd0);

    // reset inside data bit 4 of 0x0F
    send(0, 8'h0F);
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_txd", 0, 32'(txd[0]), 32'd1);
    rst  = 1'b0;
    lows = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (txd[0] !== 1'b1) lows++;
    end
    chk("abort_quiet", 0, 32'(lows), 32'd0);
    send(0, 8'h3C);
    grab(0, 40, c);
    chk("after_abort", 0, mid(c, 10), 32'h278);

    // random valid toggling with changing data on all three
    hs_cnt = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
        if (m_hs[k]) hs_cnt++;
        v[k] = 1'($urandom_range(0, 1));
        d[k] = 8'($urandom);
      end
    end
    v = '0;
    repeat (60) @(negedge clk);
    chk("stall_hs_seen", 0, 32'(hs_cnt >= 5), 32'd1);
    chk("stall_idle", 0, 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog t=%0t got no finish expected finish", $time);
    $fatal(1, "watchdog");
  end

endmodule
